// File: rtl/ls1u_pkg.sv
// Shared LS1u definitions: XCR register map and interrupt-status bit layout.
package ls1u_pkg;

    localparam logic [2:0] XCR_IMASK  = 3'd0;
    localparam logic [2:0] XCR_VBASE0 = 3'd1;
    localparam logic [2:0] XCR_VBASE1 = 3'd2;
    localparam logic [2:0] XCR_VBASE2 = 3'd3;
    localparam logic [2:0] XCR_ISTAT  = 3'd4;
    localparam logic [2:0] XCR_ICUR   = 3'd5;
    localparam logic [2:0] XCR_IPEND  = 3'd6;

    localparam int ISTAT_OVF_BIT = 7;
    localparam int ISTAT_UNF_BIT = 6;

    // Channel number; value NCH (up to 8) is the "no ISR active" sentinel.
    typedef logic [3:0] ch_t;

    function automatic logic [7:0] istat_pack(input logic ovf, input logic unf,
                                              input logic [4:0] lvl);
        return {ovf, unf, 1'b0, lvl};
    endfunction

endpackage

// File: rtl/ls1u_ctx_lifo.sv
// Context LIFO: DEPTH entries, pop has priority over push, top read is combinational.
module ls1u_ctx_lifo #(
    parameter int DEPTH = 4,
    parameter int W     = 52
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] top,
    output logic [4:0]   level,
    output logic         empty,
    output logic         full
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [4:0]   level_q, level_d;
    logic [4:0]   top_idx;
    logic         do_pop, do_push;

    assign empty   = (level_q == 5'd0);
    assign full    = (level_q == 5'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !pop && !full;
    assign top_idx = level_q - 5'd1;

    always_comb begin
        level_d = level_q;
        if (do_pop)
            level_d = level_q - 5'd1;
        else if (do_push)
            level_d = level_q + 5'd1;
    end

    // Entries are not cleared on reset; an empty stack simply reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level_q <= 5'd0;
        else
            level_q <= level_d;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[level_q[IW-1:0]] <= wdata;
    end

    assign top   = empty ? '0 : mem[top_idx[IW-1:0]];
    assign level = level_q;

endmodule

// File: rtl/ls1u_int_ctx_stack.sv
// Nested vectored interrupt controller for LS1u with a hardware context stack
// holding {return PC, data pointer, interrupted channel} per nesting level.
module ls1u_int_ctx_stack
    import ls1u_pkg::*;
#(
    parameter int NCH       = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 24,
    parameter int VEC_SHIFT = 4,
    parameter int SYNC      = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] irq,
    output logic           int_req,
    output logic [AW-1:0]  int_vec,
    input  logic           int_ack,
    input  logic [AW-1:0]  save_pc,
    input  logic [AW-1:0]  save_dp,
    input  logic           ret,
    output logic [AW-1:0]  ret_pc,
    output logic [AW-1:0]  ret_dp,
    output logic           in_isr,
    input  logic           xcr_cs,
    input  logic           xcr_we,
    input  logic [2:0]     xcr_a,
    input  logic [7:0]     xcr_wd,
    output logic [7:0]     xcr_rd
);
    localparam int W = 2*AW + 4;

    logic [NCH-1:0] irq_sync, pend;
    logic [NCH-1:0] mask_q, mask_d;
    logic [AW-1:0]  vbase_q, vbase_d;
    logic [AW-1:0]  int_vec_q, int_vec_d;
    ch_t            cur_ch_q, cur_ch_d, req_ch_q, sel, prev_ch;
    logic           int_req_q, int_req_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic           prio_ok, eligible, do_push, do_pop, xcr_wr, stat_wr;
    logic [W-1:0]   top;
    logic [4:0]     level;
    logic           empty, full;

    generate
        if (SYNC != 0) begin : g_sync
            logic [NCH-1:0] s1_q, s2_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q <= '0;
                    s2_q <= '0;
                end else begin
                    s1_q <= irq;
                    s2_q <= s1_q;
                end
            end
            assign irq_sync = s2_q;
        end else begin : g_nosync
            assign irq_sync = irq;
        end
    endgenerate

    assign pend = irq_sync & mask_q;

    always_comb begin
        sel = ch_t'(NCH);
        for (int i = NCH - 1; i >= 0; i--)
            if (pend[i]) sel = ch_t'(i);
    end

    // prio_ok without room on the stack is what raises OVF.
    assign prio_ok  = (pend != '0) && (sel < cur_ch_q);
    assign eligible = prio_ok && !full;
    assign do_pop   = ret && !empty;
    assign do_push  = int_ack && int_req_q && !ret;
    assign xcr_wr   = xcr_cs && xcr_we;
    assign stat_wr  = xcr_wr && (xcr_a == XCR_ISTAT);

    ls1u_ctx_lifo #(.DEPTH(DEPTH), .W(W)) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (do_push),
        .pop   (ret),
        .wdata ({save_pc, save_dp, cur_ch_q}),
        .top   (top),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    assign ret_pc  = top[W-1 -: AW];
    assign ret_dp  = top[AW+3 -: AW];
    assign prev_ch = top[3:0];

    always_comb begin
        mask_d    = mask_q;
        vbase_d   = vbase_q;
        cur_ch_d  = cur_ch_q;
        int_req_d = eligible && !do_push;
        int_vec_d = vbase_q + (AW'(sel) << VEC_SHIFT);
        ovf_d     = (ovf_q && !(stat_wr && xcr_wd[ISTAT_OVF_BIT])) || (prio_ok && full);
        unf_d     = (unf_q && !(stat_wr && xcr_wd[ISTAT_UNF_BIT])) || (ret && empty);
        if (xcr_wr && xcr_a == XCR_IMASK)
            mask_d = xcr_wd[NCH-1:0];
        for (int b = 0; b < AW; b++)
            if (xcr_wr && b / 8 < 3 && int'(xcr_a) == b / 8 + int'(XCR_VBASE0))
                vbase_d[b] = xcr_wd[b % 8];
        if (do_pop)
            cur_ch_d = prev_ch;
        else if (do_push)
            cur_ch_d = req_ch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            vbase_q   <= '0;
            cur_ch_q  <= ch_t'(NCH);
            req_ch_q  <= ch_t'(NCH);
            int_req_q <= 1'b0;
            int_vec_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            vbase_q   <= vbase_d;
            cur_ch_q  <= cur_ch_d;
            req_ch_q  <= sel;
            int_req_q <= int_req_d;
            int_vec_q <= int_vec_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    always_comb begin
        xcr_rd = 8'h00;
        case (xcr_a)
            XCR_IMASK: xcr_rd = 8'(mask_q);
            XCR_VBASE0, XCR_VBASE1, XCR_VBASE2: begin
                for (int b = 0; b < AW; b++)
                    if (b / 8 + int'(XCR_VBASE0) == int'(xcr_a))
                        xcr_rd[b % 8] = vbase_q[b];
            end
            XCR_ISTAT: xcr_rd = istat_pack(ovf_q, unf_q, level);
            XCR_ICUR:  xcr_rd = 8'(cur_ch_q);
            XCR_IPEND: xcr_rd = 8'(pend);
            default:   xcr_rd = 8'h00;
        endcase
    end

    assign int_req = int_req_q;
    assign int_vec = int_vec_q;
    assign in_isr  = !empty;

endmodule

// File: tb/tb_ls1u_int_ctx_stack.sv
// Directed bench: dut_a (DEPTH=4, SYNC=0) is checked against a stack-level model every
// cycle plus literal checks; dut_b (DEPTH=2, SYNC=1) covers overflow and sync latency.
module tb_ls1u_int_ctx_stack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  irq;
    logic        int_req, int_ack, ret, in_isr, xcr_cs, xcr_we;
    logic [23:0] int_vec, save_pc, save_dp, ret_pc, ret_dp;
    logic [2:0]  xcr_a;
    logic [7:0]  xcr_wd, xcr_rd;

    logic [7:0]  b_irq;
    logic        b_int_req, b_int_ack, b_ret, b_in_isr, b_cs, b_we;
    logic [23:0] b_int_vec, b_save_pc, b_save_dp, b_ret_pc, b_ret_dp;
    logic [2:0]  b_a;
    logic [7:0]  b_wd, b_rd;

    ls1u_int_ctx_stack #(.NCH(8), .DEPTH(4), .AW(24), .VEC_SHIFT(4), .SYNC(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .irq(irq), .int_req(int_req), .int_vec(int_vec),
        .int_ack(int_ack), .save_pc(save_pc), .save_dp(save_dp), .ret(ret),
        .ret_pc(ret_pc), .ret_dp(ret_dp), .in_isr(in_isr), .xcr_cs(xcr_cs),
        .xcr_we(xcr_we), .xcr_a(xcr_a), .xcr_wd(xcr_wd), .xcr_rd(xcr_rd));

    ls1u_int_ctx_stack #(.NCH(8), .DEPTH(2), .AW(24), .VEC_SHIFT(4), .SYNC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .irq(b_irq), .int_req(b_int_req), .int_vec(b_int_vec),
        .int_ack(b_int_ack), .save_pc(b_save_pc), .save_dp(b_save_dp), .ret(b_ret),
        .ret_pc(b_ret_pc), .ret_dp(b_ret_dp), .in_isr(b_in_isr), .xcr_cs(b_cs),
        .xcr_we(b_we), .xcr_a(b_a), .xcr_wd(b_wd), .xcr_rd(b_rd));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of dut_a ----------------
    typedef struct {
        logic [23:0] pc;
        logic [23:0] dp;
        int          ch;
    } ent_t;

    ent_t        m_stk[$];
    int          m_cur, m_reqch;
    logic [7:0]  m_mask;
    logic [23:0] m_vb, m_vec;
    logic        m_req, m_ovf, m_unf;

    function automatic int first_set(input logic [7:0] p);
        for (int i = 0; i < 8; i++)
            if (p[i]) return i;
        return 8;
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_cur = 8; m_reqch = 8; m_mask = 8'h00; m_vb = 24'h0;
        m_vec = 24'h0; m_req = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0]  p;
        int          s;
        bit          wants, push, nreq;
        logic [23:0] nvec;
        p     = irq & m_mask;
        s     = first_set(p);
        wants = (p != 8'h00) && (s < m_cur);
        push  = int_ack && m_req && !ret;
        nreq  = wants && (m_stk.size() < 4) && !push;
        nvec  = m_vb + 24'(s * 16);
        if (xcr_cs && xcr_we) begin
            case (xcr_a)
                3'd0: m_mask = xcr_wd;
                3'd1: m_vb[7:0]   = xcr_wd;
                3'd2: m_vb[15:8]  = xcr_wd;
                3'd3: m_vb[23:16] = xcr_wd;
                3'd4: begin
                    if (xcr_wd[7]) m_ovf = 1'b0;
                    if (xcr_wd[6]) m_unf = 1'b0;
                end
                default: ;
            endcase
        end
        if (wants && m_stk.size() == 4) m_ovf = 1'b1;
        if (ret) begin
            if (m_stk.size() > 0) begin
                m_cur = m_stk[$].ch;
                void'(m_stk.pop_back());
            end else begin
                m_unf = 1'b1;
            end
        end else if (push) begin
            m_stk.push_back('{pc: save_pc, dp: save_dp, ch: m_cur});
            m_cur = m_reqch;
        end
        m_req   = nreq;
        m_vec   = nvec;
        m_reqch = s;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare process: one cycle-by-cycle check of every dut_a output.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            begin
                logic [7:0] exp_rd;
                logic [7:0] lvl;
                lvl = 8'(m_stk.size());
                case (xcr_a)
                    3'd0: exp_rd = m_mask;
                    3'd1: exp_rd = m_vb[7:0];
                    3'd2: exp_rd = m_vb[15:8];
                    3'd3: exp_rd = m_vb[23:16];
                    3'd4: exp_rd = {m_ovf, m_unf, 1'b0, lvl[4:0]};
                    3'd5: exp_rd = 8'(m_cur);
                    3'd6: exp_rd = irq & m_mask;
                    default: exp_rd = 8'h00;
                endcase
                chk("model int_req", 32'(int_req), 32'(m_req));
                if (m_req) chk("model int_vec", 32'(int_vec), 32'(m_vec));
                chk("model in_isr", 32'(in_isr), 32'(m_stk.size() != 0));
                chk("model ret_pc", 32'(ret_pc), m_stk.size() ? 32'(m_stk[$].pc) : 32'h0);
                chk("model ret_dp", 32'(ret_dp), m_stk.size() ? 32'(m_stk[$].dp) : 32'h0);
                chk("model xcr_rd", 32'(xcr_rd), 32'(exp_rd));
            end
        end
    end

    // ---------------- stimulus helpers for dut_a (called at a falling edge) ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        xcr_cs = 1'b1; xcr_we = 1'b1; xcr_a = a; xcr_wd = d;
        @(negedge clk);
        xcr_cs = 1'b0; xcr_we = 1'b0;
    endtask

    task automatic rd(input string n, input logic [2:0] a, input logic [7:0] exp);
        xcr_a = a;
        #1;
        chk(n, 32'(xcr_rd), 32'(exp));
    endtask

    task automatic wait_req(input string n);
        int k;
        k = 0;
        while (!int_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(n, 32'(int_req), 32'h1);
    endtask

    task automatic ack(input logic [23:0] pc, input logic [23:0] dp);
        int_ack = 1'b1; save_pc = pc; save_dp = dp;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic do_ret();
        ret = 1'b1;
        @(negedge clk);
        ret = 1'b0;
    endtask

    initial begin
        irq = 8'h00; int_ack = 1'b0; ret = 1'b0; save_pc = '0; save_dp = '0;
        xcr_cs = 1'b0; xcr_we = 1'b0; xcr_a = 3'd0; xcr_wd = 8'h00;
        b_irq = 8'h00; b_int_ack = 1'b0; b_ret = 1'b0; b_save_pc = '0; b_save_dp = '0;
        b_cs = 1'b0; b_we = 1'b0; b_a = 3'd0; b_wd = 8'h00;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;

        chk("reset int_req", 32'(int_req), 32'h0);
        chk("reset in_isr", 32'(in_isr), 32'h0);
        chk("reset ret_pc", 32'(ret_pc), 32'h0);
        rd("reset cur_ch", 3'd5, 8'h08);
        rd("reset status", 3'd4, 8'h00);

        wr(3'd0, 8'hFF); wr(3'd1, 8'h00); wr(3'd2, 8'h10); wr(3'd3, 8'h00);
        rd("vbase1 readback", 3'd2, 8'h10);

        // ch3 request, 1-cycle latency with SYNC=0
        irq[3] = 1'b1;
        @(negedge clk);
        chk("ch3 int_req latency", 32'(int_req), 32'h1);
        chk("ch3 int_vec", 32'(int_vec), 32'h001030);
        ack(24'h000123, 24'h0000AA);
        chk("int_req dropped after ack", 32'(int_req), 32'h0);
        chk("in_isr after ack", 32'(in_isr), 32'h1);
        rd("cur_ch after ack", 3'd5, 8'h03);
        rd("level 1", 3'd4, 8'h01);
        irq[3] = 1'b0;

        // ch1 preempts ch3
        irq[1] = 1'b1;
        @(negedge clk);
        chk("ch1 preempt req", 32'(int_req), 32'h1);
        chk("ch1 int_vec", 32'(int_vec), 32'h001010);
        ack(24'h000456, 24'h0000BB);
        irq[1] = 1'b0;
        rd("level 2", 3'd4, 8'h02);

        // ch5 is lower priority: waits
        irq[5] = 1'b1;
        cyc(3);
        chk("ch5 held off", 32'(int_req), 32'h0);
        chk("top ret_pc ch1", 32'(ret_pc), 32'h000456);
        do_ret();
        chk("ret_pc after 1st ret", 32'(ret_pc), 32'h000123);
        chk("ch5 still held", 32'(int_req), 32'h0);
        do_ret();
        chk("int_req in ret cycle", 32'(int_req), 32'h0);
        @(negedge clk);
        chk("ch5 serviced", 32'(int_req), 32'h1);
        chk("ch5 int_vec", 32'(int_vec), 32'h001050);
        ack(24'h000789, 24'h0000CC);
        irq[5] = 1'b0;
        do_ret();

        // nest 6,4,2,0 to full depth
        irq[6] = 1'b1; wait_req("nest ch6"); ack(24'h000600, 24'h000006);
        irq[4] = 1'b1; wait_req("nest ch4"); ack(24'h000400, 24'h000004);
        irq[2] = 1'b1; wait_req("nest ch2"); ack(24'h000200, 24'h000002);
        irq[0] = 1'b1; wait_req("nest ch0"); ack(24'h000100, 24'h000001);
        rd("level 4", 3'd4, 8'h04);
        cyc(2);
        chk("ch0 re-raise no req", 32'(int_req), 32'h0);
        rd("no OVF for equal prio", 3'd4, 8'h04);

        // mask test
        irq[0] = 1'b0; irq[2] = 1'b0;
        wr(3'd0, 8'h00);
        rd("pend masked", 3'd6, 8'h00);
        do_ret(); do_ret(); do_ret();
        cyc(2);
        chk("masked ch4 no req", 32'(int_req), 32'h0);
        wr(3'd0, 8'hFF);
        @(negedge clk);
        chk("unmask ch4 req", 32'(int_req), 32'h1);
        chk("unmask ch4 vec", 32'(int_vec), 32'h001040);
        irq[4] = 1'b0; irq[6] = 1'b0;
        cyc(2);
        chk("cleared src no req", 32'(int_req), 32'h0);
        do_ret();
        chk("stack empty", 32'(in_isr), 32'h0);

        // underflow
        do_ret();
        rd("UNF set", 3'd4, 8'h40);
        wr(3'd4, 8'h40);
        rd("UNF cleared", 3'd4, 8'h00);

        // ret and int_ack together at level 1
        irq[2] = 1'b1; wait_req("sc ch2"); ack(24'h000222, 24'h000022);
        irq[0] = 1'b1; wait_req("sc ch0");
        ret = 1'b1; int_ack = 1'b1; save_pc = 24'h000999; save_dp = 24'h000099;
        @(negedge clk);
        ret = 1'b0; int_ack = 1'b0;
        rd("ret+ack level 0", 3'd4, 8'h00);
        chk("ret+ack no push", 32'(ret_pc), 32'h0);
        chk("ret+ack req re-eval", 32'(int_req), 32'h1);
        chk("ret+ack vec ch0", 32'(int_vec), 32'h001000);
        ack(24'h000333, 24'h000033);
        rd("cur ch0", 3'd5, 8'h00);
        irq = 8'h00;
        do_ret();

        // asynchronous reset mid-ISR at level 3
        irq[6] = 1'b1; wait_req("rst ch6"); ack(24'h000A06, 24'h0);
        irq[4] = 1'b1; wait_req("rst ch4"); ack(24'h000A04, 24'h0);
        irq[2] = 1'b1; wait_req("rst ch2"); ack(24'h000A02, 24'h0);
        rd("level 3", 3'd4, 8'h03);
        irq[1] = 1'b1; wait_req("rst ch1 pending");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst int_req", 32'(int_req), 32'h0);
        chk("async rst in_isr", 32'(in_isr), 32'h0);
        chk("async rst ret_pc", 32'(ret_pc), 32'h0);
        chk("async rst status", 32'(xcr_rd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);
        chk("mask=0 after rst", 32'(int_req), 32'h0);
        rd("pend after rst", 3'd6, 8'h00);
        irq = 8'h00;

        // ---------------- dut_b: DEPTH=2, SYNC=1 ----------------
        b_cs = 1'b1; b_we = 1'b1; b_a = 3'd0; b_wd = 8'hFF;
        @(negedge clk);
        b_cs = 1'b0; b_we = 1'b0;
        b_irq[5] = 1'b1;
        @(negedge clk);
        chk("B sync clk1", 32'(b_int_req), 32'h0);
        @(negedge clk);
        chk("B sync clk2", 32'(b_int_req), 32'h0);
        @(negedge clk);
        chk("B sync clk3", 32'(b_int_req), 32'h1);
        chk("B ch5 vec", 32'(b_int_vec), 32'h000050);
        b_int_ack = 1'b1; b_save_pc = 24'h005000;
        @(negedge clk);
        b_int_ack = 1'b0;
        b_irq[3] = 1'b1;
        for (int k = 0; k < 10 && !b_int_req; k++) @(negedge clk);
        chk("B ch3 req", 32'(b_int_req), 32'h1);
        chk("B ch3 vec", 32'(b_int_vec), 32'h000030);
        b_int_ack = 1'b1; b_save_pc = 24'h003000;
        @(negedge clk);
        b_int_ack = 1'b0;
        b_irq[1] = 1'b1;
        cyc(5);
        chk("B full holds ch1", 32'(b_int_req), 32'h0);
        b_a = 3'd4;
        #1;
        chk("B OVF status", 32'(b_rd), 32'h82);
        chk("B top ret_pc", 32'(b_ret_pc), 32'h003000);
        b_ret = 1'b1;
        @(negedge clk);
        b_ret = 1'b0;
        chk("B ret cycle no req", 32'(b_int_req), 32'h0);
        chk("B ret_pc after pop", 32'(b_ret_pc), 32'h005000);
        @(negedge clk);
        chk("B ch1 after pop", 32'(b_int_req), 32'h1);
        chk("B ch1 vec", 32'(b_int_vec), 32'h000010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ls1u_int_ctx_stack.md
Name:
ls1u_int_ctx_stack

Overview:
- Nested, vectored interrupt controller with a hardware context stack for the LS1u CPU family.
- Replaces the single INT / IVEC_addr input and the single-level RET/RTA save registers with NCH prioritised channels and DEPTH levels of nesting.
- Sits between the peripheral IRQ lines and the CPU core; configured over the XCR bus.

Parameters:
- NCH, 8, number of IRQ channels (1..8); channel 0 has the highest priority.
- DEPTH, 4, context stack depth, which is also the maximum nesting level (1..16).
- AW, 24, width of the PC and of the data-pointer {A2,A1,A0}.
- VEC_SHIFT, 4, log2 byte stride between vectors.
- SYNC, 1, when 1 each irq line passes through a 2-flop synchroniser.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irq  in  NCH  level-sensitive interrupt requests, active high
- int_req  out  1  registered interrupt request to the CPU
- int_vec  out  AW  registered vector address for int_req
- int_ack  in  1  CPU takes the interrupt this cycle
- save_pc  in  AW  return PC pushed on int_ack
- save_dp  in  AW  {A2,A1,A0} pushed on int_ack
- ret  in  1  CPU executes RET this cycle (pop)
- ret_pc  out  AW  top-of-stack return PC (combinational from the stack)
- ret_dp  out  AW  top-of-stack data pointer
- in_isr  out  1  stack level is nonzero
- xcr_cs  in  1  XCR select
- xcr_we  in  1  XCR write
- xcr_a  in  3  XCR register address
- xcr_wd  in  8  XCR write data
- xcr_rd  out  8  XCR read data (combinational)

Behaviour:
- Reset values:
  - int_req=0, int_vec=0, in_isr=0, level=0.
  - cur_ch=NCH (idle sentinel), mask=0, vec_base=0, sticky flags=0.
  - ret_pc and ret_dp read 0 while the stack is empty.
  - Synchroniser flops reset to 0.
  - Reset mid-ISR discards the whole stack.
- pend = irq_sync & mask.
- sel = lowest index i with pend[i].
- Eligibility: eligible = pend nonzero, sel < cur_ch, and level < DEPTH.
- Register update every cycle:
  - int_req <= eligible
  - int_vec <= vec_base + (sel << VEC_SHIFT), truncated to AW
- Latency: irq rises -> int_req rises after 1 clk (SYNC=0) or 3 clk (SYNC=1).
- int_ack with int_req=1 and ret=0:
  - Push {save_pc, save_dp, cur_ch}; level++; cur_ch <= the channel latched with int_req.
  - int_req is forced to 0 in the following cycle.
- int_ack with int_req=0: ignored.
- ret with level>0: pop; cur_ch <= stored prev channel; level--. ret_pc/ret_dp present the entry being popped during the ret cycle.
- ret with level=0: no state change; sets sticky UNF.
- ret and int_ack in the same cycle: ret wins; ack ignored, no push.
- Requests while full:
  - An eligible-by-priority request arriving at level=DEPTH is held off (int_req=0) and sets sticky OVF.
  - It is serviced after a pop.
- Preemption: only strictly higher priority. An equal or lower channel waits until a ret brings cur_ch above it.
- IRQ is level-sensitive: the ISR must clear the source before ret, else the request re-fires 1 clk later.
- XCR map (write when xcr_cs & xcr_we; reads combinational):
  - 0: mask[NCH-1:0], RW.
  - 1..3: vec_base bytes 0..2, RW; bits above AW are ignored.
  - 4: status {OVF, UNF, 1'b0, level[4:0]}, read; writing 1 to bit 7 or bit 6 clears that flag.
  - 5: cur_ch, RO.
  - 6: pend, RO.
  - 7: reads 0.
- A mask write takes effect on the next int_req evaluation (1 clk). It never retracts an already-acked interrupt.

Decomposition:
- Shared package ls1u_pkg holds the XCR register address constants (XCR_IMASK, XCR_VBASE0..2, XCR_ISTAT, XCR_ICUR, XCR_IPEND) and the status bit positions.
- One sub-module, ls1u_ctx_lifo: a DEPTH-entry LIFO with width 2*AW+4, push/pop/level and a top-of-stack read port.
- Priority encoder and XCR decode stay inline.

Test Plan:
- Reset; mask=0xFF, vec_base=0x001000, SYNC=0; assert irq[3] -> int_req=1, int_vec=0x001030 after 1 clk; ack with save_pc=0x000123 -> cur_ch=3, level=1, in_isr=1.
- Within the ch3 ISR raise irq[1] -> preempt, int_vec=0x001010, level=2; raise irq[5] -> no int_req; ret twice -> ret_pc sequence is the ch1 save then 0x000123, after which ch5 is serviced.
- DEPTH=4: nest channels 6,4,2,0 -> level=4; raising a higher channel is not possible, so re-raise ch0 plus mask test; assert ret at level 0 -> UNF=1; write 0x40 to addr 4 -> UNF=0.
- DEPTH=2 build: nest ch5, ch3, then raise ch1 -> int_req stays 0, OVF=1; ret -> ch1 int_req within 1 clk.
- Drive ret and int_ack in the same cycle at level=1 -> level=0, no push, int_req re-evaluated next clk.
- Assert rst_n low mid-ISR at level=3 -> all outputs at reset values immediately (asynchronous); with irq held and mask=0 after release -> int_req stays 0.
